serial_adder: RTL and testbench
===============================

# serial_adder

Parametrised digit-serial adder/subtractor: two WIDTH-bit operands are added DIGIT bits per clock through a registered carry, under a start/busy/done handshake. It trades latency for area relative to a flat combinational adder. The digit slice reuses the full-adder equations (sum = a^b^c, carry = majority) rippled DIGIT times. It sits as a shared arithmetic unit behind a simple controller that issues one operation at a time.

## Interface
- WIDTH, 8, operand and result width in bits; ≥ 2
- DIGIT, 1, bits processed per cycle; must divide WIDTH (elaboration-time error otherwise)
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous and active-high
- start  in  1  request; sampled only in IDLE or DONE
- a  in  WIDTH  operand A; captured when start is accepted
- b  in  WIDTH  operand B; captured when start is accepted
- cin  in  1  carry-in for add mode; captured with operands
- sub  in  1  mode: 0 = a+b+cin, 1 = a−b (cin ignored); captured with operands
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse on entry to DONE
- sum  out  WIDTH  result; valid from done until the next accepted start
- cout  out  1  final carry out (sub mode: 1 = no borrow)
- ovf  out  1  two's-complement signed overflow of the result

## Operation
- States: IDLE, RUN, DONE. N = WIDTH/DIGIT digit steps.
- IDLE: start=1 → capture a, b (inverted when sub=1), carry = sub ? 1 : cin; clear digit count; → RUN.
- RUN: each cycle adds the least-significant DIGIT bits of the A/B shift registers plus the carry register; the DIGIT-bit result shifts into sum from the MSB end; carry register updated; count increments. After step N → DONE.
- DONE: done=1 for this cycle only; sum/cout/ovf reflect the completed operation. start=1 here is accepted exactly as in IDLE (back-to-back); otherwise → IDLE.
- start in RUN is ignored; operands and mode changing in RUN have no effect.
- ovf = carry into MSB XOR carry out of MSB, taken on the final step; registered with cout.
- sum, cout and ovf hold their last values in IDLE. They are undefined while busy=1. The bench must not check them then.

## Timing
- Reset values: state IDLE, busy 0, done 0, sum 0, cout 0, ovf 0, count 0, carry 0.
- Start accepted at edge E0. busy is high in cycles E0..E(N−1). The result registers on edge EN, and done is high in the cycle after EN.
- Latency is N+1 cycles from the accepting edge to done. Back-to-back throughput is one operation per N+1 cycles.
- rst asserted in any state, including mid-RUN, returns all registers to reset values at that edge. The partial operation is discarded and no done is produced.
- rst and start high together: rst wins.

## Structure
- Package serial_adder_pkg: state_t enum {IDLE, RUN, DONE}; a localparam helper for count width, $clog2(WIDTH/DIGIT)+1.
- Sub-module serial_adder_digit: combinational DIGIT-bit ripple of full-adder cells. Inputs: a, b, cin. Outputs: sum, cout, and the carry into the top bit (for ovf). Instantiated once.
- Top: FSM, count, operand shift registers, carry register, result registers.

## Test plan
- WIDTH=8, DIGIT=1: a=8'hFF, b=8'h01, cin=0, sub=0 → sum=8'h00, cout=1, ovf=0; done exactly 9 cycles after the accepting edge; busy high 8 cycles.
- WIDTH=8, DIGIT=1: a=8'h7F, b=8'h01, cin=0 → sum=8'h80, cout=0, ovf=1. Then a=8'h05, b=8'h07, sub=1 → sum=8'hFE, cout=0, ovf=0.
- WIDTH=8, DIGIT=4: a=8'h3C, b=8'h4D, cin=1 → sum=8'h8A, cout=0, ovf=1; done 3 cycles after start. Second start held high in the done cycle → second operation accepted with no IDLE gap.
- start pulsed during RUN with different operands → ignored; result matches the first operation; one done only.
- rst asserted at step 3 of an 8-step run → next cycle busy=0, done=0, sum=0, cout=0, ovf=0. No done follows. A new start then completes correctly.
- WIDTH=4, DIGIT ∈ {1,2,4}: exhaustive a, b, cin, sub → {cout,sum} equals a+b+cin (add) or a+~b+1 (sub); ovf matches the signed reference.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// ============================================================
// Package : serial_adder_pkg
// Shared state encoding and sizing helper for serial_adder.
// Rev     : 1.0
// ============================================================
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One extra bit so the counter can represent the full step count N.
  function automatic int count_width(input int width, input int digit);
    return $clog2(width / digit) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_adder_if.sv
// ============================================================
// Interface : serial_adder_if
// Operand/result bundle with start/busy/done handshake.
// Rev       : 1.0
// ============================================================
`default_nettype none

interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

`default_nettype wire

// File: rtl/serial_adder_digit.sv
// ============================================================
// Module : serial_adder_digit
// Combinational DIGIT-bit ripple of full-adder cells.
// Rev    : 1.0
// ============================================================
`default_nettype none

module serial_adder_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_top
);

  // c_top is the carry entering the most significant bit of this digit.
  always_comb begin
    logic carry;
    carry = cin;
    c_top = cin;
    sum   = '0;
    for (int i = 0; i < DIGIT; i++) begin
      c_top  = carry;
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
    end
    cout = carry;
  end

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================
// Module : serial_adder
// Digit-serial adder/subtractor, DIGIT bits per clock.
// Rev    : 1.0
// ============================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int                 C_STEPS = WIDTH / DIGIT;
  localparam int                 C_CNT_W = count_width(WIDTH, DIGIT);
  localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(C_STEPS - 1);

  if ((DIGIT < 1) || (WIDTH < 2) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("serial_adder: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end

  state_t             state_q, state_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [DIGIT-1:0]   w_dig_sum;
  logic               w_dig_cout;
  logic               w_dig_ctop;
  logic [WIDTH-1:0]   w_sum_shift;

  serial_adder_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .sum   (w_dig_sum),
    .cout  (w_dig_cout),
    .c_top (w_dig_ctop)
  );

  // Result digits enter at the MSB so after N steps the LSB digit lands at bit 0.
  if (DIGIT == WIDTH) begin : g_sum_single
    assign w_sum_shift = w_dig_sum;
  end else begin : g_sum_multi
    assign w_sum_shift = {w_dig_sum, sum_q[WIDTH-1:DIGIT]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub | bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = w_dig_cout;
        sum_d   = w_sum_shift;
        cnt_d   = cnt_q + C_CNT_W'(1);
        if (cnt_q == C_LAST) begin
          cout_d  = w_dig_cout;
          ovf_d   = w_dig_cout ^ w_dig_ctop;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================
// Module : tb_serial_adder
// Scoreboard bench for serial_adder in five WIDTH/DIGIT configurations.
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_serial_adder;

  localparam int NDUT = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start_v [NDUT];
  logic [7:0] a_v     [NDUT];
  logic [7:0] b_v     [NDUT];
  logic       cin_v   [NDUT];
  logic       sub_v   [NDUT];
  logic       busy_v  [NDUT];
  logic       done_v  [NDUT];
  logic [7:0] sum_v   [NDUT];
  logic       cout_v  [NDUT];
  logic       ovf_v   [NDUT];

  logic [9:0] exp_q [NDUT][$];
  logic [9:0] mon_exp;
  int errors = 0;
  int checks = 0;

  serial_adder_if #(.WIDTH(8)) if0 ();
  serial_adder_if #(.WIDTH(8)) if1 ();
  serial_adder_if #(.WIDTH(4)) if2 ();
  serial_adder_if #(.WIDTH(4)) if3 ();
  serial_adder_if #(.WIDTH(4)) if4 ();

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  serial_adder #(.WIDTH(8), .DIGIT(4)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  serial_adder #(.WIDTH(4), .DIGIT(1)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  serial_adder #(.WIDTH(4), .DIGIT(2)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
  serial_adder #(.WIDTH(4), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  assign if0.start = start_v[0]; assign if0.a = a_v[0]; assign if0.b = b_v[0];
  assign if0.cin = cin_v[0]; assign if0.sub = sub_v[0];
  assign busy_v[0] = if0.busy; assign done_v[0] = if0.done; assign sum_v[0] = if0.sum;
  assign cout_v[0] = if0.cout; assign ovf_v[0] = if0.ovf;

  assign if1.start = start_v[1]; assign if1.a = a_v[1]; assign if1.b = b_v[1];
  assign if1.cin = cin_v[1]; assign if1.sub = sub_v[1];
  assign busy_v[1] = if1.busy; assign done_v[1] = if1.done; assign sum_v[1] = if1.sum;
  assign cout_v[1] = if1.cout; assign ovf_v[1] = if1.ovf;

  assign if2.start = start_v[2]; assign if2.a = a_v[2][3:0]; assign if2.b = b_v[2][3:0];
  assign if2.cin = cin_v[2]; assign if2.sub = sub_v[2];
  assign busy_v[2] = if2.busy; assign done_v[2] = if2.done; assign sum_v[2] = {4'b0, if2.sum};
  assign cout_v[2] = if2.cout; assign ovf_v[2] = if2.ovf;

  assign if3.start = start_v[3]; assign if3.a = a_v[3][3:0]; assign if3.b = b_v[3][3:0];
  assign if3.cin = cin_v[3]; assign if3.sub = sub_v[3];
  assign busy_v[3] = if3.busy; assign done_v[3] = if3.done; assign sum_v[3] = {4'b0, if3.sum};
  assign cout_v[3] = if3.cout; assign ovf_v[3] = if3.ovf;

  assign if4.start = start_v[4]; assign if4.a = a_v[4][3:0]; assign if4.b = b_v[4][3:0];
  assign if4.cin = cin_v[4]; assign if4.sub = sub_v[4];
  assign busy_v[4] = if4.busy; assign done_v[4] = if4.done; assign sum_v[4] = {4'b0, if4.sum};
  assign cout_v[4] = if4.cout; assign ovf_v[4] = if4.ovf;

  function automatic int width_of(input int i);
    return (i < 2) ? 8 : 4;
  endfunction

  function automatic int steps_of(input int i);
    case (i)
      0:       return 8;
      1:       return 2;
      2:       return 4;
      3:       return 2;
      default: return 1;
    endcase
  endfunction

  // Reference: plain integer arithmetic, packed as {ovf, cout, sum[7:0]}.
  function automatic logic [9:0] model(input int w, input int a, input int b,
                                       input bit cin, input bit sub);
    int mask, ua, ub, full, sa, sb, r, half;
    logic [9:0] res;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    ua   = a & mask;
    ub   = b & mask;
    full = sub ? (ua + ((~ub) & mask) + 1) : (ua + ub + int'(cin));
    sa   = (ua >= half) ? ua - (1 << w) : ua;
    sb   = (ub >= half) ? ub - (1 << w) : ub;
    r    = sub ? (sa - sb) : (sa + sb + int'(cin));
    res[7:0] = 8'(full & mask);
    res[8]   = ((full >> w) & 1) != 0;
    res[9]   = (r > half - 1) || (r < -half);
    return res;
  endfunction

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (done_v[i] === 1'b1) begin
        checks++;
        if (exp_q[i].size() == 0) begin
          errors++;
          $display("FAIL done_unexpected dut%0d: got done=1 (sum=%h), required no done", i, sum_v[i]);
        end else begin
          mon_exp = exp_q[i].pop_front();
          if ({ovf_v[i], cout_v[i], sum_v[i]} !== mon_exp) begin
            errors++;
            $display("FAIL result dut%0d: got ovf=%b cout=%b sum=%h, required ovf=%b cout=%b sum=%h",
                     i, ovf_v[i], cout_v[i], sum_v[i], mon_exp[9], mon_exp[8], mon_exp[7:0]);
          end
        end
      end
    end
  end

  task automatic check_eq(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic check_idle(input int i, input string name);
    check_eq(name, int'({busy_v[i], done_v[i], sum_v[i], cout_v[i], ovf_v[i]}), 0);
  endtask

  task automatic drive(input int i, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub, input bit push);
    a_v[i] = a; b_v[i] = b; cin_v[i] = cin; sub_v[i] = sub; start_v[i] = 1'b1;
    if (push) exp_q[i].push_back(model(width_of(i), a, b, cin, sub));
  endtask

  // Returns just after the accepting edge E0; start is lowered unless hold is set.
  task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub, input bit push, input bit hold);
    @(posedge clk); #1;
    drive(i, a, b, cin, sub, push);
    @(posedge clk); #1;
    if (!hold) start_v[i] = 1'b0;
  endtask

  task automatic measure(input int i, output int first_done, output int busy_cnt);
    first_done = 0;
    busy_cnt   = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (busy_v[i] === 1'b1) busy_cnt++;
      if (done_v[i] === 1'b1) begin
        first_done = k;
        break;
      end
    end
  endtask

  task automatic drain(input int i);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (exp_q[i].size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout dut%0d: got %0d results outstanding, required 0", i, exp_q[i].size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

  initial begin
    int fd, bc, d1, d2, ndone;
    for (int i = 0; i < NDUT; i++) begin
      start_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0; cin_v[i] = 1'b0; sub_v[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) check_idle(i, $sformatf("reset_state_dut%0d", i));

    // FF + 01: wraps to zero with carry out; latency and busy length.
    issue(0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    measure(0, fd, bc);
    check_eq("w8d1_done_cycle", fd, 9);
    check_eq("w8d1_busy_cycles", bc, 8);
    drain(0);

    issue(0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    drain(0);
    issue(0, 8'h05, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
    drain(0);

    // DIGIT=4, then back-to-back second operation with start held into DONE.
    issue(1, 8'h3C, 8'h4D, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1, 8'h80, 8'h01, 1'b0, 1'b1, 1'b1);
    d1 = 0; d2 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done_v[1] === 1'b1) begin
        if (d1 == 0) d1 = k;
        else if (d2 == 0) d2 = k;
      end
      if (d1 != 0 && k == d1 + 1) start_v[1] = 1'b0;
      if (d2 != 0) break;
    end
    start_v[1] = 1'b0;
    check_eq("w8d4_done_cycle", d1, 3);
    check_eq("w8d4_b2b_done_cycle", d2, 6);
    drain(1);

    // start pulsed mid-RUN with other operands must be ignored.
    issue(0, 8'h55, 8'h2A, 1'b1, 1'b0, 1'b1, 1'b0);
    fd = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 3) begin
        a_v[0] = 8'h11; b_v[0] = 8'h22; sub_v[0] = 1'b1; start_v[0] = 1'b1;
      end
      if (k == 5) start_v[0] = 1'b0;
      if (done_v[0] === 1'b1 && fd == 0) fd = k;
    end
    check_eq("ignore_start_done_cycle", fd, 9);
    drain(0);

    // Reset in the middle of a run discards the operation.
    issue(0, 8'h9C, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle(0, "midrun_reset_state");
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) ndone++;
    end
    check_eq("midrun_reset_no_done", ndone, 0);
    issue(0, 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
    measure(0, fd, bc);
    check_eq("after_reset_done_cycle", fd, 9);
    drain(0);

    // Random operations on both 8-bit configurations.
    for (int n = 0; n < 25; n++) begin
      issue(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
      drain(0);
      issue(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
      drain(1);
    end

    // Exhaustive 4-bit sweep on all three digit sizes in parallel.
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int m = 0; m < 3; m++) begin
          @(posedge clk); #1;
          for (int i = 2; i < NDUT; i++)
            drive(i, 8'(av), 8'(bv), (m == 1), (m == 2), 1'b1);
          @(posedge clk); #1;
          for (int i = 2; i < NDUT; i++) start_v[i] = 1'b0;
          for (int i = 2; i < NDUT; i++) drain(i);
        end
      end
    end

    repeat (5) @(posedge clk);
    for (int i = 0; i < NDUT; i++)
      check_eq($sformatf("leftover_results_dut%0d", i), exp_q[i].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
